// File: rtl/multi_slot_accumulator.sv
// Multi-slot accumulator: DEPTH slots of WIDTH+1 bits, one ADD/ACC/SUB/CLR
// per accepted command, registered result with valid/ready, sticky ovf.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     command handshake (op, slot, a, b)
//   out_valid/out_ready   result handshake (result, out_slot)
//   ovf                   sticky per-slot carry/borrow flags
`timescale 1ns/1ps
module multi_slot_accumulator #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    slot,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic [AW-1:0]    out_slot,
  output logic [DEPTH-1:0] ovf
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ACC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic [WIDTH:0]   mem [DEPTH];
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   r;
  logic             acc;
  logic             is_add;
  logic             is_acc;
  logic             is_sub;
  logic             is_clr;

  assign in_ready = !out_valid | out_ready;
  assign acc      = in_valid & in_ready;

  assign is_add = (op == OP_ADD);
  assign is_acc = (op == OP_ACC);
  assign is_sub = (op == OP_SUB);
  assign is_clr = (op == OP_CLR);

  // Stored carry bit is never fed back as an operand.
  always_comb begin
    s = mem[slot][WIDTH-1:0];
    r = '0;
    unique case (1'b1)
      is_add:  r = {1'b0, a} + {1'b0, b};
      is_acc:  r = {1'b0, s} + {1'b0, a};
      is_sub:  r = {1'b0, s} - {1'b0, a};
      is_clr:  r = '0;
      default: r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_slot  <= '0;
      ovf       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (acc) begin
        mem[slot] <= r;
        result    <= r;
        out_slot  <= slot;
        out_valid <= 1'b1;
        if (is_clr) begin
          ovf[slot] <= 1'b0;
        end else if (r[WIDTH]) begin
          ovf[slot] <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
